// File: rtl/text_console_renderer.sv
// text_console_renderer: COLS x ROWS text console rendered into per-pixel RGB.
// A byte-stream writer maintains a cursor and a simple dual-port text RAM;
// a 4-stage render pipeline maps (x,y) to a cell, fetches its glyph from the
// external font ROM and selects foreground/background colour.
// Optional feature macro: TEXT_CURSOR_EN (blinking inverted cursor cell).
// Writer handshake: a byte transfers on a rising clk edge where
// i_wr_valid & o_wr_ready; o_wr_ready is low while the screen is clearing.
module text_console_renderer #(
  parameter int COLS         = 120,
  parameter int ROWS         = 75,
  parameter int SCALE_LOG2   = 0,
  parameter int COORD_W      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_wr_valid,
  input  logic [7:0]                i_wr_char,
  output logic                      o_wr_ready,
  output logic [$clog2(COLS)-1:0]   o_cur_col,
  output logic [$clog2(ROWS)-1:0]   o_cur_row,
  input  logic                      i_pix_valid,
  input  logic [COORD_W-1:0]        i_x,
  input  logic [COORD_W-1:0]        i_y,
  input  logic                      i_frame_start,
  input  logic [23:0]               i_fg_color,
  input  logic [23:0]               i_bg_color,
  output logic [6:0]                o_font_addr,
  input  logic [127:0]              i_font_data,
  output logic                      o_pix_valid,
  output logic [23:0]               o_color
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  typedef enum logic {ST_CLEAR, ST_IDLE} wr_state_t;

  wr_state_t       state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            wr_ready_q, wr_ready_d;
  logic            wr_fire, ram_we;
  logic [AW-1:0]   ram_waddr, cur_addr, ram_raddr;
  logic [6:0]      ram_wdata, rd_char_q;
  logic [6:0]      mem [CELLS];

  assign o_wr_ready = wr_ready_q;
  assign o_cur_col  = col_q;
  assign o_cur_row  = row_q;
  assign cur_addr   = AW'(row_q) * AW'(COLS) + AW'(col_q);

  // Writer next state: auto-clear sweep, printable store with cursor wrap, control codes
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    col_d      = col_q;
    row_d      = row_q;
    wr_ready_d = wr_ready_q;
    ram_we     = 1'b0;
    ram_waddr  = clr_idx_q;
    ram_wdata  = 7'h20;
    wr_fire    = i_wr_valid & wr_ready_q;
    case (state_q)
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (clr_idx_q == AW'(CELLS - 1)) begin
          state_d    = ST_IDLE;
          wr_ready_d = 1'b1;
          clr_idx_d  = '0;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (wr_fire) begin
          if (i_wr_char >= 8'h20 && i_wr_char <= 8'h7E) begin
            ram_we    = 1'b1;
            ram_waddr = cur_addr;
            ram_wdata = i_wr_char[6:0];
            if (col_q == CW'(COLS - 1)) begin
              col_d = '0;
              row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end else begin
            case (i_wr_char)
              8'h0D: col_d = '0;
              8'h0A: row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
              8'h08: if (col_q != '0) col_d = col_q - CW'(1);
              8'h0C: begin
                state_d    = ST_CLEAR;
                wr_ready_d = 1'b0;
                clr_idx_d  = '0;
                col_d      = '0;
                row_d      = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  // Writer state registers; reset restarts the clear from cell 0
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_CLEAR;
      clr_idx_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      col_q      <= col_d;
      row_q      <= row_d;
      wr_ready_q <= wr_ready_d;
    end
  end

  // Text RAM: write port from writer/clear, registered read port for render (read-old on collision)
  always_ff @(posedge i_clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    rd_char_q <= mem[ram_raddr];
  end

  // ---------------- cursor blink ----------------
  logic blink_on;
`ifdef TEXT_CURSOR_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  // Count frame pulses; flip blink phase every BLINK_FRAMES pulses
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (i_frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Blink registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
  assign blink_on = blink_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = i_frame_start;
  assign blink_on = 1'b0;
`endif

  // ---------------- render pipeline ----------------
  logic [COORD_W-1:0] col_c, row_c, col0_q, row0_q;
  logic [2:0]         gx_c, gx0_q, gx1_q, gx2_q;
  logic [3:0]         gy_c, gy0_q, gy1_q, gy2_q;
  logic               out_c, inv_c, v0_q, v1_q, v2_q, out0_q, out1_q, out2_q;
  logic               inv0_q, inv1_q, inv2_q, pix_valid_q, pix_valid_d, pix_on;
  logic [6:0]         bit_idx;
  logic [23:0]        color_q, color_d;

  // Request decode into cell coordinates and glyph offsets; colour selection at the tail
  always_comb begin
    col_c   = i_x >> (3 + SCALE_LOG2);
    row_c   = i_y >> (4 + SCALE_LOG2);
    gx_c    = 3'(i_x >> SCALE_LOG2);
    gy_c    = 4'(i_y >> SCALE_LOG2);
    out_c   = (col_c >= COORD_W'(COLS)) || (row_c >= COORD_W'(ROWS));
    inv_c   = blink_on && !out_c && (col_c == COORD_W'(col_q)) && (row_c == COORD_W'(row_q));
    ram_raddr = out0_q ? '0 : AW'(row0_q) * AW'(COLS) + AW'(col0_q);
    bit_idx = {gy2_q, ~gx2_q};
    pix_on  = i_font_data[bit_idx] & ~out2_q;
    pix_valid_d = v2_q;
    color_d = color_q;
    if (v2_q) color_d = (pix_on ^ inv2_q) ? i_fg_color : i_bg_color;
  end

  // Pipeline registers: S0 decode, S1 RAM read, S2 font fetch, S3 colour out
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0;
      col0_q <= '0; row0_q <= '0; gx0_q <= '0; gy0_q <= '0; out0_q <= 1'b0; inv0_q <= 1'b0;
      gx1_q <= '0; gy1_q <= '0; out1_q <= 1'b0; inv1_q <= 1'b0;
      gx2_q <= '0; gy2_q <= '0; out2_q <= 1'b0; inv2_q <= 1'b0;
      pix_valid_q <= 1'b0;
      color_q     <= '0;
    end else begin
      v0_q <= i_pix_valid; col0_q <= col_c; row0_q <= row_c;
      gx0_q <= gx_c; gy0_q <= gy_c; out0_q <= out_c; inv0_q <= inv_c;
      v1_q <= v0_q; gx1_q <= gx0_q; gy1_q <= gy0_q; out1_q <= out0_q; inv1_q <= inv0_q;
      v2_q <= v1_q; gx2_q <= gx1_q; gy2_q <= gy1_q; out2_q <= out1_q; inv2_q <= inv1_q;
      pix_valid_q <= pix_valid_d;
      color_q     <= color_d;
    end
  end

  assign o_font_addr = rd_char_q;
  assign o_pix_valid = pix_valid_q;
  assign o_color     = color_q;
endmodule

// File: tb/tb_text_console_renderer.sv
// Testbench for text_console_renderer: random writer streams and pixel requests
// checked against a screen/cursor model and a font ROM model.
module tb_text_console_renderer;
  localparam int COLS = 120;
  localparam int ROWS = 75;
  localparam int S    = 0;
  localparam int BLINK = 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         wr_valid = 1'b0;
  logic [7:0]   wr_char = '0;
  logic         wr_ready;
  logic [6:0]   cur_col, cur_row;
  logic         pix_valid_in = 1'b0;
  logic [11:0]  px = '0, py = '0;
  logic         frame_start = 1'b0;
  logic [23:0]  fg = 24'hFFFFFF, bg = 24'h000000;
  logic [6:0]   font_addr;
  logic [127:0] font_data = '0;
  logic         pix_valid_out;
  logic [23:0]  color;

  text_console_renderer dut (
    .i_clk(clk), .i_reset(rst), .i_wr_valid(wr_valid), .i_wr_char(wr_char),
    .o_wr_ready(wr_ready), .o_cur_col(cur_col), .o_cur_row(cur_row),
    .i_pix_valid(pix_valid_in), .i_x(px), .i_y(py), .i_frame_start(frame_start),
    .i_fg_color(fg), .i_bg_color(bg), .o_font_addr(font_addr), .i_font_data(font_data),
    .o_pix_valid(pix_valid_out), .o_color(color)
  );

  // ---------------- font ROM model (0x20 blank, others hashed) ----------------
  function automatic logic [127:0] font_bits(logic [6:0] c);
    logic [127:0] g;
    logic [31:0] w;
    g = '0;
    if (c == 7'h20) return g;
    for (int k = 0; k < 4; k++) begin
      w = (({25'd0, c} + 32'd1) * 32'h9E3779B9) ^ ((32'(k) + 32'd1) * 32'h85EBCA6B);
      w = w ^ (w >> 15);
      g[k*32 +: 32] = w;
    end
    return g;
  endfunction
  always @(posedge clk) font_data <= font_bits(font_addr);

  // ---------------- reference model ----------------
  logic [6:0] cells [ROWS][COLS];
  int mcol = 0, mrow = 0, frames = 0;

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) cells[r][c] = 7'h20;
    mcol = 0;
    mrow = 0;
  endfunction

  function automatic void model_apply(logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      cells[mrow][mcol] = b[6:0];
      mcol = mcol + 1;
      if (mcol == COLS) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
      end
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) mrow = (mrow + 1) % ROWS;
    else if (b == 8'h08) begin
      if (mcol > 0) mcol = mcol - 1;
    end else if (b == 8'h0C) model_clear();
  endfunction

  function automatic logic [23:0] exp_pix(int x, int y);
    int c, r, gx, gy;
    logic [127:0] g;
    bit on, swap;
    c = x / (8 << S);
    r = y / (16 << S);
    if (c >= COLS || r >= ROWS) return bg;
    gx = (x / (1 << S)) % 8;
    gy = (y / (1 << S)) % 16;
    g  = font_bits(cells[r][c]);
    on = g[gy*8 + 7 - gx];
    swap = 1'b0;
`ifdef TEXT_CURSOR_EN
    swap = ((frames / BLINK) % 2 == 1) && (c == mcol) && (r == mrow);
`endif
    return (on ^ swap) ? fg : bg;
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];
  int          cyc_q[$];
  int tests = 0, fails = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented pixel pops one expectation, checks colour and latency
  always @(negedge clk) begin
    if (!rst && pix_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pix", 64'd1, 64'd0);
      end else begin
        logic [23:0] e;
        int c0;
        e  = exp_q.pop_front();
        c0 = cyc_q.pop_front();
        check("pix_color", color, e);
        check("pix_latency", cyc - c0, 4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(logic [7:0] b);
    int n = 0;
    wr_valid = 1'b1;
    wr_char  = b;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (n > 20000) begin
        check("send_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    if (n <= 20000) model_apply(b);
  endtask

  task automatic pix(int x, int y, bit v);
    pix_valid_in = v;
    px = 12'(x);
    py = 12'(y);
    if (v) begin
      exp_q.push_back(exp_pix(x, y));
      cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    pix_valid_in = 1'b0;
  endtask

  task automatic new_colors();
    fg = 24'($urandom);
    bg = 24'($urandom);
    if (fg == bg) bg = ~fg;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic scan_rand(int n);
    new_colors();
    for (int i = 0; i < n; i++)
      pix($urandom_range(0, 1023), $urandom_range(0, 1279), $urandom_range(0, 3) != 0);
    drain();
  endtask

  task automatic scan_cell(int c, int r);
    new_colors();
    for (int gy = 0; gy < (16 << S); gy++)
      for (int gx = 0; gx < (8 << S); gx++)
        pix(c * (8 << S) + gx, r * (16 << S) + gy, 1'b1);
    drain();
  endtask

  task automatic wait_clear(string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (n > 20000) break;
    end
    check(name, n, 9000);
    @(posedge clk);
    #1;
  endtask

  task automatic check_cursor(string name);
    check({name, "_col"}, cur_col, mcol);
    check({name, "_row"}, cur_row, mrow);
  endtask

  task automatic frame_pulses(int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      frames++;
    end
  endtask

  task automatic random_stream(int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h0C) b = 8'h41;
      send_byte(b);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_clear();
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", wr_ready, 0);
    check("rst_pix_valid", pix_valid_out, 0);
    check("rst_color", color, 0);
    check("rst_col", cur_col, 0);
    check("rst_row", cur_row, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clear("init_clear_cycles");
    check_cursor("after_init");

    // blank screen, including the right/bottom edges and just outside
    new_colors();
    pix(960, 0, 1'b1); pix(959, 1199, 1'b1); pix(0, 1200, 1'b1); pix(0, 0, 1'b1);
    drain();
    scan_rand(400);

    // single glyph then full row wrap
    send_byte(8'h41);
    check_cursor("after_A");
    scan_cell(0, 0);
    for (int i = 0; i < 119; i++) send_byte(8'($urandom_range(8'h21, 8'h7E)));
    check_cursor("row_wrap");
    scan_rand(300);

    // last cell wraps cursor to origin
    for (int i = 0; i < 73; i++) send_byte(8'h0A);
    for (int i = 0; i < 119; i++) send_byte(8'($urandom_range(8'h21, 8'h7E)));
    check_cursor("at_last_cell");
    send_byte(8'h42);
    check_cursor("screen_wrap");
    scan_cell(119, 74);

    // control codes at (5,3)
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) send_byte(8'h2A);
    check_cursor("at_5_3");
    send_byte(8'h0D); check_cursor("cr");
    send_byte(8'h08); check_cursor("bs_sat");
    send_byte(8'h0A); check_cursor("lf");
    send_byte(8'h01); check_cursor("ignored");
    check("ignored_ready", wr_ready, 1);
    send_byte(8'h51); send_byte(8'h08); check_cursor("bs");
    scan_cell(0, 4);

    // random byte stream
    random_stream(300);
    check_cursor("rand_stream");
    scan_rand(800);

    // form feed clear
    send_byte(8'h0C);
    wait_clear("ff_clear_cycles");
    check_cursor("after_ff");
    scan_rand(300);

    // reset in the middle of a clear restarts it from cell 0
    random_stream(200);
    send_byte(8'h0C);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midclr_rst_ready", wr_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    frames = 0;
    wait_clear("restart_clear_cycles");
    scan_rand(300);

    // cursor blink around cell (2,1)
    send_byte(8'h0A); send_byte(8'h78); send_byte(8'h79);
    send_byte(8'h5A); send_byte(8'h08);
    check_cursor("blink_pos");
    frame_pulses(BLINK - 1);
    scan_cell(2, 1);
    frame_pulses(1);
    scan_cell(2, 1);
    scan_cell(3, 1);
    frame_pulses(BLINK);
    scan_cell(2, 1);

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
